fetch_stage: RTL and testbench

//   Parametrised IF stage with built-in IF/ID register. Holds the PC, steps it by PC_STEP and drives the instruction-memory address.

---
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage with built-in IF/ID register: PC sequencing, stall/flush/redirect handling,
// sticky misaligned-redirect flag and a saturating count of instructions delivered to ID.
module fetch_stage #(
   parameter int unsigned     XLEN      = 64,
   parameter int unsigned     ILEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     PC_STEP   = 4,
   parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h00000013),
   parameter int unsigned     CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [ILEN-1:0]  imem_rdata,
   output logic             id_valid,
   output logic [ILEN-1:0]  id_instr,
   output logic [XLEN-1:0]  id_pc,
   output logic             misalign_err,
   output logic [CNT_W-1:0] fetch_count
);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic             id_valid_q, id_valid_d;
   logic [ILEN-1:0]  id_instr_q, id_instr_d;
   logic [XLEN-1:0]  id_pc_q, id_pc_d;
   logic             misalign_q, misalign_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  pc_inc;

   // Modulo-2^XLEN add: wrapping past the top of the address space is silent.
   assign pc_inc = pc_q + XLEN'(PC_STEP);

   always_comb begin
      pc_d       = pc_q;
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      misalign_d = misalign_q;
      cnt_d      = cnt_q;
      if (redirect_valid) begin
         pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
         id_valid_d = 1'b0;
         id_instr_d = NOP_INSTR;
         id_pc_d    = '0;
         if (redirect_pc[1:0] != 2'b00)
            misalign_d = 1'b1;
      end else if (flush) begin
         // The instruction fetched this cycle is dropped; PC still moves unless stalled.
         id_valid_d = 1'b0;
         id_instr_d = NOP_INSTR;
         id_pc_d    = '0;
         if (!stall)
            pc_d = pc_inc;
      end else if (!stall) begin
         id_valid_d = 1'b1;
         id_instr_d = imem_rdata;
         id_pc_d    = pc_q;
         pc_d       = pc_inc;
         if (cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         id_valid_q <= 1'b0;
         id_instr_q <= NOP_INSTR;
         id_pc_q    <= '0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   assign imem_addr    = pc_q;
   assign id_valid     = id_valid_q;
   assign id_instr     = id_instr_q;
   assign id_pc        = id_pc_q;
   assign misalign_err = misalign_q;
   assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: default instance (a) for sequencing/stall/redirect/misalign,
// small-counter instance near the top of the address space (b) for wrap and saturation.
module tb_fetch_stage;

   localparam logic [63:0] B_RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance a
   logic        a_reset, a_stall, a_flush, a_rv;
   logic [63:0] a_rpc, a_addr, a_id_pc;
   logic [31:0] a_rdata, a_instr, a_cnt;
   logic        a_valid, a_mis;
   assign a_rdata = 32'h100 + a_addr[31:0];

   fetch_stage dut_a (
      .clk(clk), .reset(a_reset), .stall(a_stall), .flush(a_flush),
      .redirect_valid(a_rv), .redirect_pc(a_rpc), .imem_addr(a_addr),
      .imem_rdata(a_rdata), .id_valid(a_valid), .id_instr(a_instr),
      .id_pc(a_id_pc), .misalign_err(a_mis), .fetch_count(a_cnt)
   );

   // instance b
   logic        b_reset, b_stall, b_flush, b_rv;
   logic [63:0] b_rpc, b_addr, b_id_pc;
   logic [31:0] b_rdata, b_instr;
   logic [1:0]  b_cnt;
   logic        b_valid, b_mis;
   assign b_rdata = 32'h100 + b_addr[31:0];

   fetch_stage #(.RESET_PC(B_RESET_PC), .CNT_W(2)) dut_b (
      .clk(clk), .reset(b_reset), .stall(b_stall), .flush(b_flush),
      .redirect_valid(b_rv), .redirect_pc(b_rpc), .imem_addr(b_addr),
      .imem_rdata(b_rdata), .id_valid(b_valid), .id_instr(b_instr),
      .id_pc(b_id_pc), .misalign_err(b_mis), .fetch_count(b_cnt)
   );

   typedef struct {
      int          due;
      int          sig;
      string       name;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   function automatic logic [63:0] actual(int s);
      case (s)
         0: return a_addr;
         1: return 64'(a_valid);
         2: return 64'(a_instr);
         3: return a_id_pc;
         4: return 64'(a_mis);
         5: return 64'(a_cnt);
         6: return b_addr;
         7: return 64'(b_valid);
         8: return 64'(b_cnt);
         9: return b_id_pc;
         default: return 'x;
      endcase
   endfunction

   // expectation for the state after the next rising edge
   task automatic ex(input int s, input string n, input logic [63:0] e);
      exp_t t;
      t.due  = cyc + 1;
      t.sig  = s;
      t.name = n;
      t.exp  = e;
      sb.push_back(t);
   endtask

   // monitor: compare every expectation that has come due
   initial forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t t;
         logic [63:0] act;
         t   = sb.pop_front();
         act = actual(t.sig);
         n_tot++;
         if (act === t.exp) n_pass++;
         else $display("FAIL %s: got %h expected %h (cycle %0d)", t.name, act, t.exp, cyc);
      end
   end

   task automatic a_drive(input logic r, input logic s, input logic f,
                          input logic rv, input logic [63:0] rpc);
      a_reset = r; a_stall = s; a_flush = f; a_rv = rv; a_rpc = rpc;
   endtask

   task automatic a_state(input string tag, input logic [63:0] addr, input logic v,
                          input logic [31:0] ins, input logic [63:0] pc, input logic [31:0] cnt);
      ex(0, {tag, ".imem_addr"}, addr);
      ex(1, {tag, ".id_valid"}, 64'(v));
      ex(2, {tag, ".id_instr"}, 64'(ins));
      ex(3, {tag, ".id_pc"}, pc);
      ex(5, {tag, ".fetch_count"}, 64'(cnt));
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      a_drive(1, 0, 0, 0, 64'h0);
      b_reset = 1; b_stall = 0; b_flush = 0; b_rv = 0; b_rpc = '0;

      // reset held two cycles
      step();
      a_state("reset", 64'h0, 0, 32'h13, 64'h0, 0);
      ex(4, "reset.misalign", 64'h0);
      step();

      // sequential fetch from 0
      a_drive(0, 0, 0, 0, 64'h0);
      a_state("seq0", 64'h4, 1, 32'h100, 64'h0, 1); step();
      a_state("seq1", 64'h8, 1, 32'h104, 64'h4, 2); step();
      a_state("seq2", 64'hC, 1, 32'h108, 64'h8, 3); step();

      // stall two cycles at pc 0xC
      a_drive(0, 1, 0, 0, 64'h0);
      a_state("stall0", 64'hC, 1, 32'h108, 64'h8, 3); step();
      a_state("stall1", 64'hC, 1, 32'h108, 64'h8, 3); step();
      a_drive(0, 0, 0, 0, 64'h0);
      a_state("unstall", 64'h10, 1, 32'h10C, 64'hC, 4); step();

      // redirect wins over stall and flush
      a_drive(0, 1, 1, 1, 64'h40);
      a_state("redir", 64'h40, 0, 32'h13, 64'h0, 4);
      ex(4, "redir.misalign", 64'h0); step();
      a_drive(0, 0, 0, 0, 64'h0);
      a_state("redir_next", 64'h44, 1, 32'h140, 64'h40, 5); step();

      // flush without stall advances pc, flush with stall holds it
      a_drive(0, 0, 1, 0, 64'h0);
      a_state("flush", 64'h48, 0, 32'h13, 64'h0, 5); step();
      a_drive(0, 1, 1, 0, 64'h0);
      a_state("flush_stall", 64'h48, 0, 32'h13, 64'h0, 5); step();

      // misaligned redirect is sticky
      a_drive(0, 0, 0, 1, 64'h42);
      a_state("misredir", 64'h40, 0, 32'h13, 64'h0, 5);
      ex(4, "misredir.misalign", 64'h1); step();
      a_drive(0, 0, 0, 0, 64'h0);
      for (int i = 0; i < 10; i++) begin
         if (i == 9) begin
            a_state("after10", 64'h68, 1, 32'h164, 64'h64, 15);
            ex(4, "after10.misalign", 64'h1);
         end
         step();
      end

      // reset beats concurrent stall + redirect
      a_drive(1, 1, 0, 1, 64'h81);
      a_state("rst_mid", 64'h0, 0, 32'h13, 64'h0, 0);
      ex(4, "rst_mid.misalign", 64'h0); step();

      // instance b: wrap and 2-bit saturation
      a_drive(1, 0, 0, 0, 64'h0);
      ex(6, "b.reset.imem_addr", B_RESET_PC);
      ex(8, "b.reset.fetch_count", 64'h0); step();
      b_reset = 0;
      ex(6, "b.adv0.imem_addr", 64'hFFFF_FFFF_FFFF_FFFC);
      ex(9, "b.adv0.id_pc", B_RESET_PC);
      ex(8, "b.adv0.fetch_count", 64'h1); step();
      b_flush = 1;
      ex(6, "b.flush.imem_addr", 64'h0);
      ex(7, "b.flush.id_valid", 64'h0);
      ex(8, "b.flush.fetch_count", 64'h1); step();
      b_flush = 0;
      ex(6, "b.adv1.imem_addr", 64'h4);
      ex(9, "b.adv1.id_pc", 64'h0);
      ex(8, "b.adv1.fetch_count", 64'h2); step();
      ex(8, "b.adv2.fetch_count", 64'h3); step();
      ex(8, "b.sat0.fetch_count", 64'h3);
      ex(7, "b.sat0.id_valid", 64'h1); step();
      ex(6, "b.sat1.imem_addr", 64'h10);
      ex(8, "b.sat1.fetch_count", 64'h3); step();

      // drain scoreboard with a bounded wait
      for (int i = 0; i < 20 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
         n_tot += sb.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
